// File: rtl/display_pkg.sv
// display_pkg -- shared definitions for the serial display driver.
//   MAX7219 register addresses, driver FSM state type, and the power-up
//   init ROM used when DISPLAY_INIT_EN is defined.
package display_pkg;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT1    = 4'h2;
  localparam logic [3:0] REG_DIGIT2    = 4'h3;
  localparam logic [3:0] REG_DIGIT3    = 4'h4;
  localparam logic [3:0] REG_DIGIT4    = 4'h5;
  localparam logic [3:0] REG_DIGIT5    = 4'h6;
  localparam logic [3:0] REG_DIGIT6    = 4'h7;
  localparam logic [3:0] REG_DIGIT7    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } state_e;

  localparam int unsigned INIT_LEN = 5;

  // Power-up sequence, sent in index order.
  function automatic logic [15:0] init_word(input logic [2:0] idx);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {4'h0, REG_SHUTDOWN,  8'h01};
      3'd1:    w = {4'h0, REG_SCANLIMIT, 8'h05};
      3'd2:    w = {4'h0, REG_DECODE,    8'hFF};
      3'd3:    w = {4'h0, REG_INTENSITY, 8'h08};
      3'd4:    w = {4'h0, REG_TEST,      8'h00};
      default: w = {4'h0, REG_NOOP,      8'h00};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/serial_display_driver_if.sv
// serial_display_driver_if -- valid/ready word handshake into the driver.
//   word       : command word (addr[11:8], data[7:0])
//   word_valid : word is valid (master -> slave)
//   word_ready : slave accepts word this cycle (slave -> master)
interface serial_display_driver_if #(
  parameter int unsigned WORD_W = 16
);
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              word_ready;

  modport master (output word, output word_valid, input word_ready);
  modport slave  (input word, input word_valid, output word_ready);
endinterface

// File: rtl/serial_sck_gen.sv
// serial_sck_gen -- SCK generator for the serial display link.
//   clk_i, rst_ni : system clock, async active-low reset
//   run_i         : high while a frame is shifting; low parks sck at 0
//   sck_o         : shift clock, CLK_DIV cycles low then CLK_DIV cycles high
//   rise_o/fall_o : high in the cycle whose closing edge raises/lowers sck
module serial_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             last;

  assign last   = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign rise_o = run_i && last && !sck_q;
  assign fall_o = run_i && last && sck_q;
  assign sck_o  = sck_q;

  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!run_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      sck_d = !sck_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/serial_display_driver.sv
// serial_display_driver -- shifts MAX7219 command words MSB-first over a
// 3-wire link (LOAD, DOUT, SCK).
//   i_clk, i_reset_n : system clock, async active-low reset
//   i_en             : low blocks acceptance of new words (frames in flight finish)
//   word_if          : slave side of the word valid/ready handshake
//   o_busy           : frame or init sequence in progress
//   o_serial_dout    : serial data, changes on SCK falling edges
//   o_serial_clk     : SCK, f(i_clk)/(2*CLK_DIV)
//   o_serial_load    : LOAD/CS, low while shifting, high CLK_DIV cycles after
// Frame: SHIFT for 2*CLK_DIV*WORD_W cycles, LATCH for CLK_DIV cycles.
// Optional: define DISPLAY_INIT_EN to auto-send the package init ROM after
// reset release; the handshake stays closed until that sequence ends.
module serial_display_driver
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned WORD_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_en,
  serial_display_driver_if.slave   word_if,
  output logic                     o_busy,
  output logic                     o_serial_dout,
  output logic                     o_serial_clk,
  output logic                     o_serial_load
);

  localparam int unsigned HOLD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W  = $clog2(WORD_W + 1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               load_q, load_d;
  logic               sck_rise, sck_fall;
  logic               ready;
  logic               init_busy;

`ifdef DISPLAY_INIT_EN
  logic               init_pend_q, init_pend_d;
  logic [2:0]         init_idx_q, init_idx_d;

  assign init_busy = init_pend_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      init_pend_q <= 1'b1;
      init_idx_q  <= '0;
    end else begin
      init_pend_q <= init_pend_d;
      init_idx_q  <= init_idx_d;
    end
  end
`else
  assign init_busy = 1'b0;
`endif

  serial_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .run_i  (state_q == ST_SHIFT),
    .sck_o  (o_serial_clk),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  assign ready              = (state_q == ST_IDLE) && i_en && !init_busy;
  assign word_if.word_ready = ready;
  assign o_busy             = (state_q != ST_IDLE) || init_busy;
  assign o_serial_dout      = shreg_q[WORD_W-1];
  assign o_serial_load      = load_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    hold_d    = hold_q;
    load_d    = load_q;
`ifdef DISPLAY_INIT_EN
    init_pend_d = init_pend_q;
    init_idx_d  = init_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef DISPLAY_INIT_EN
        if (init_pend_q) begin
          state_d    = ST_SHIFT;
          shreg_d    = WORD_W'(init_word(init_idx_q));
          bit_cnt_d  = '0;
          load_d     = 1'b0;
          init_idx_d = init_idx_q + 3'd1;
          if (init_idx_q == 3'(INIT_LEN - 1)) init_pend_d = 1'b0;
        end else
`endif
        if (word_if.word_valid && ready) begin
          state_d   = ST_SHIFT;
          shreg_d   = word_if.word;
          bit_cnt_d = '0;
          load_d    = 1'b0;
        end
      end
      ST_SHIFT: begin
        // Bits are counted as the display samples them (rising edge); the
        // falling edge after the last sample ends the frame instead of shifting.
        if (sck_rise) bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (sck_fall) begin
          if (bit_cnt_q == BIT_W'(WORD_W)) begin
            state_d = ST_LATCH;
            load_d  = 1'b1;
            hold_d  = '0;
          end else begin
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
          end
        end
      end
      ST_LATCH: begin
        if (hold_q == HOLD_W'(CLK_DIV - 1)) state_d = ST_IDLE;
        else                                hold_d  = hold_q + HOLD_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      hold_q    <= '0;
      load_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      hold_q    <= hold_d;
      load_q    <= load_d;
    end
  end

endmodule

// File: tb/tb_serial_display_driver.sv
// tb_serial_display_driver -- two drivers (CLK_DIV=2 and CLK_DIV=1) share one
// random stimulus stream; each is checked cycle by cycle against a frame-timing
// model and frame by frame against words decoded from its SCK/DOUT/LOAD pins.
module tb_serial_display_driver;

`ifdef DISPLAY_INIT_EN
  localparam int unsigned INIT_N = 5;
`else
  localparam int unsigned INIT_N = 0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] word  = '0;

  always #5 clk = ~clk;

  serial_display_driver_if #(.WORD_W(16)) bus0 ();
  serial_display_driver_if #(.WORD_W(16)) bus1 ();

  assign bus0.word       = word;
  assign bus0.word_valid = valid;
  assign bus1.word       = word;
  assign bus1.word_valid = valid;

  logic [1:0] busy_w, dout_w, sck_w, load_w, ready_w;
  assign ready_w = {bus1.word_ready, bus0.word_ready};

  serial_display_driver #(.CLK_DIV(2), .WORD_W(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .word_if(bus0),
    .o_busy(busy_w[0]), .o_serial_dout(dout_w[0]),
    .o_serial_clk(sck_w[0]), .o_serial_load(load_w[0])
  );

  serial_display_driver #(.CLK_DIV(1), .WORD_W(16)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .word_if(bus1),
    .o_busy(busy_w[1]), .o_serial_dout(dout_w[1]),
    .o_serial_clk(sck_w[1]), .o_serial_load(load_w[1])
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned div_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic logic [15:0] rom(input int unsigned i);
    case (i)
      0:       return 16'h0C01;
      1:       return 16'h0B05;
      2:       return 16'h09FF;
      3:       return 16'h0A08;
      default: return 16'h0F00;
    endcase
  endfunction

  // Model: a frame occupies 33*D cycles after its accepting edge; cycle k=1..32D
  // is bit 15-(k-1)/(2D) with SCK high in the second half of each 2D window.
  int unsigned left[2]      = '{0, 0};
  int unsigned init_left[2] = '{INIT_N, INIT_N};
  logic [15:0] cur[2]       = '{16'h0, 16'h0};
  logic [15:0] exp0[$];
  logic [15:0] exp1[$];

  task automatic push_exp(input int g, input logic [15:0] w);
    if (g == 0) exp0.push_back(w);
    else        exp1.push_back(w);
  endtask

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        left[g] = 0;
        cur[g] = '0;
        init_left[g] = INIT_N;
        if (g == 0) exp0.delete();
        else        exp1.delete();
      end else if (left[g] > 0) begin
        left[g]--;
      end else if (init_left[g] > 0) begin
        cur[g] = rom(INIT_N - init_left[g]);
        init_left[g]--;
        push_exp(g, cur[g]);
        left[g] = 33 * div_of(g);
      end else if (valid && en) begin
        cur[g] = word;
        push_exp(g, word);
        left[g] = 33 * div_of(g);
      end
    end
    #1;
    for (int g = 0; g < 2; g++) begin
      int unsigned d, k;
      logic        e_load, e_sck, e_dout;
      logic [15:0] c;
      d = div_of(g);
      c = cur[g];
      e_load = 1'b1;
      e_sck  = 1'b0;
      e_dout = c[0];
      if (left[g] > 0) begin
        k = 33 * d - left[g] + 1;
        if (k <= 32 * d) begin
          e_load = 1'b0;
          e_sck  = ((k - 1) % (2 * d)) >= d;
          e_dout = c[15 - (k - 1) / (2 * d)];
        end
      end
      check_eq($sformatf("load[%0d]", g),  load_w[g],  e_load);
      check_eq($sformatf("sck[%0d]", g),   sck_w[g],   e_sck);
      check_eq($sformatf("dout[%0d]", g),  dout_w[g],  e_dout);
      check_eq($sformatf("busy[%0d]", g),  busy_w[g],  (left[g] > 0) || (init_left[g] > 0));
      check_eq($sformatf("ready[%0d]", g), ready_w[g], (left[g] == 0) && (init_left[g] == 0) && en);
    end
  end

  // Pin-level decode: what the display would latch on each LOAD rising edge.
  for (genvar g = 0; g < 2; g++) begin : mon
    logic [15:0] sh = '0;
    logic [15:0] e;
    int unsigned nb = 0;
    int unsigned qs;

    always @(posedge sck_w[g]) if (rst_n === 1'b1) begin
      sh = {sh[14:0], dout_w[g]};
      nb++;
    end

    always @(negedge rst_n) begin
      sh = '0;
      nb = 0;
    end

    always @(posedge load_w[g]) if (rst_n === 1'b1) begin
      qs = (g == 0) ? exp0.size() : exp1.size();
      check_eq($sformatf("pending[%0d]", g), qs, 1);
      if (qs > 0) begin
        e = (g == 0) ? exp0.pop_front() : exp1.pop_front();
        check_eq($sformatf("frame[%0d]", g), sh, e);
      end
      check_eq($sformatf("nbits[%0d]", g), nb, 16);
      nb = 0;
    end
  end

  task automatic random_phase(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 3) != 0);
      en    = ($urandom_range(0, 15) != 0);
      word  = 16'($urandom);
    end
  endtask

  initial begin
    logic found;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (INIT_N * 70 + 5) @(negedge clk);

    // Single directed word, then idle long enough to see ready return.
    valid = 1'b1;
    word  = 16'h0C01;
    @(negedge clk);
    valid = 1'b0;
    word  = 16'hFFFF;
    repeat (75) @(negedge clk);

    // i_en low with valid high: nothing may start.
    en = 1'b0;
    valid = 1'b1;
    word = 16'hA5A5;
    repeat (10) @(negedge clk);
    en = 1'b1;

    random_phase(1500);

    // Reset in the middle of a CLK_DIV=2 frame (around bit 8, SCK high).
    en = 1'b1;
    valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      word = 16'($urandom);
      if (left[0] == 35) found = 1'b1;
    end
    check_eq("reset_window", found, 1'b1);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("rst_load[%0d]", g), load_w[g], 1'b1);
      check_eq($sformatf("rst_sck[%0d]", g),  sck_w[g],  1'b0);
      check_eq($sformatf("rst_dout[%0d]", g), dout_w[g], 1'b0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (INIT_N * 70) @(negedge clk);

    random_phase(800);

    valid = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("drain0", exp0.size(), 0);
    check_eq("drain1", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
